// File: rtl/core_alu_wb_pkg.sv
// Shared instruction-set constants for the ALU write-back stage: opcodes,
// SFR addresses, PSW bit positions and the commit FSM state encoding.
package core_alu_wb_pkg;

  localparam logic [4:0] ALU_ADD  = 5'd0;
  localparam logic [4:0] ALU_ADDC = 5'd1;
  localparam logic [4:0] ALU_SUB  = 5'd2;
  localparam logic [4:0] ALU_INC  = 5'd3;
  localparam logic [4:0] ALU_DEC  = 5'd4;
  localparam logic [4:0] ALU_AND  = 5'd5;
  localparam logic [4:0] ALU_OR   = 5'd6;
  localparam logic [4:0] ALU_XOR  = 5'd7;
  localparam logic [4:0] ALU_RL   = 5'd8;
  localparam logic [4:0] ALU_RR   = 5'd9;
  localparam logic [4:0] ALU_DA   = 5'd10;
  localparam logic [4:0] ALU_COMP = 5'd11;
  localparam logic [4:0] ALU_MUL  = 5'd12;
  localparam logic [4:0] ALU_DIV  = 5'd13;

  localparam logic [7:0] SFR_ACC = 8'hE0;
  localparam logic [7:0] SFR_B   = 8'hF0;
  localparam logic [7:0] SFR_PSW = 8'hD0;

  localparam int PSW_CY  = 7;
  localparam int PSW_AC  = 6;
  localparam int PSW_F0  = 5;
  localparam int PSW_RS1 = 4;
  localparam int PSW_RS0 = 3;
  localparam int PSW_OV  = 2;
  localparam int PSW_F1  = 1;
  localparam int PSW_P   = 0;

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_WR_ACC = 2'd1,
    ST_WR_B   = 2'd2,
    ST_DONE   = 2'd3
  } wb_state_e;

endpackage

// File: rtl/core_alu_wb.sv
// ALU write-back: commits an ALU result to ACC/B through the SFR bus and keeps PSW.
// Define ALU_WB_SFR_ACK_EN to make each SFR write wait for sfr_ack_i.
module core_alu_wb
  import core_alu_wb_pkg::*;
(
  input  logic        clk_i,
  input  logic        rst_n_i,
  input  logic        wb_start_i,
  input  logic [4:0]  wb_opcode_i,
  input  logic [15:0] alu_result_i,
  input  logic        alu_cy_i,
  input  logic        alu_ac_i,
  input  logic        alu_ov_i,
  input  logic        psw_wr_i,
  input  logic [7:0]  psw_data_i,
  output logic        sfr_we_o,
  output logic [7:0]  sfr_addr_o,
  output logic [7:0]  sfr_data_o,
  input  logic        sfr_ack_i,
  output logic [7:0]  acc_o,
  output logic [7:0]  psw_o,
  output logic        cy_o,
  output logic        ac_o,
  output logic        ov_o,
  output logic        eq_o,
  output logic        busy_o,
  output logic        done_o
);

  wb_state_e   r_state;
  wb_state_e   w_next_state;
  logic [15:0] r_result;
  logic [4:0]  r_opcode;
  logic [7:0]  r_acc;
  logic [7:1]  r_psw;
  logic        r_eq;

  logic        w_capture;
  logic        w_wr_done;
  logic        w_is_mul;
  logic        w_is_div;
  logic [7:0]  w_acc_val;
  logic [7:0]  w_b_val;
  logic        w_unused;

`ifdef ALU_WB_SFR_ACK_EN
  assign w_wr_done = sfr_ack_i;
  assign w_unused  = psw_data_i[0];
`else
  assign w_wr_done = 1'b1;
  assign w_unused  = ^{psw_data_i[0], sfr_ack_i};
`endif

  assign w_capture = (r_state == ST_IDLE) && wb_start_i;
  assign w_is_mul  = (r_opcode == ALU_MUL);
  assign w_is_div  = (r_opcode == ALU_DIV);
  // DIV leaves the quotient in ACC and the remainder in B; MUL the reverse halves.
  assign w_acc_val = w_is_div ? r_result[15:8] : r_result[7:0];
  assign w_b_val   = w_is_mul ? r_result[15:8] : r_result[7:0];

  // NOTE: every signal driven here gets a default first so no path infers a latch.
  always_comb begin
    w_next_state = r_state;
    sfr_we_o     = 1'b0;
    sfr_addr_o   = 8'h00;
    sfr_data_o   = 8'h00;
    done_o       = 1'b0;
    case (r_state)
      ST_IDLE: begin
        if (wb_start_i) begin
          w_next_state = (wb_opcode_i == ALU_COMP) ? ST_DONE : ST_WR_ACC;
        end
      end
      ST_WR_ACC: begin
        sfr_we_o   = 1'b1;
        sfr_addr_o = SFR_ACC;
        sfr_data_o = w_acc_val;
        if (w_wr_done) begin
          w_next_state = (w_is_mul || w_is_div) ? ST_WR_B : ST_DONE;
        end
      end
      ST_WR_B: begin
        sfr_we_o   = 1'b1;
        sfr_addr_o = SFR_B;
        sfr_data_o = w_b_val;
        if (w_wr_done) begin
          w_next_state = ST_DONE;
        end
      end
      ST_DONE: begin
        done_o       = 1'b1;
        w_next_state = ST_IDLE;
      end
      default: w_next_state = ST_IDLE;
    endcase
  end

  // NOTE: state is updated with non-blocking assignments so every register samples pre-edge values.
  always_ff @(posedge clk_i or negedge rst_n_i) begin
    if (!rst_n_i) begin
      r_state  <= ST_IDLE;
      r_result <= 16'h0000;
      r_opcode <= ALU_ADD;
      r_acc    <= 8'h00;
      r_psw    <= 7'h00;
      r_eq     <= 1'b0;
    end else begin
      r_state <= w_next_state;
      if (w_capture) begin
        r_result      <= alu_result_i;
        r_opcode      <= wb_opcode_i;
        r_eq          <= (wb_opcode_i == ALU_COMP) ? alu_result_i[0] : 1'b0;
        r_psw[PSW_CY] <= alu_cy_i;
        if (wb_opcode_i != ALU_COMP) begin
          r_psw[PSW_AC] <= alu_ac_i;
          r_psw[PSW_OV] <= alu_ov_i;
        end
      end
      if ((r_state == ST_WR_ACC) && w_wr_done) begin
        r_acc <= w_acc_val;
      end
      // Placed last so a direct PSW write overrides flags captured on the same edge.
      if (psw_wr_i) begin
        r_psw <= psw_data_i[7:1];
      end
    end
  end

  assign acc_o  = r_acc;
  assign psw_o  = {r_psw, ^r_acc};
  assign cy_o   = r_psw[PSW_CY];
  assign ac_o   = r_psw[PSW_AC];
  assign ov_o   = r_psw[PSW_OV];
  assign eq_o   = r_eq;
  assign busy_o = (r_state != ST_IDLE);

endmodule

// File: tb/tb_core_alu_wb.sv
// Directed bench for core_alu_wb with hand-computed expected values.
// The ALU_WB_SFR_ACK_EN section runs only when that macro is defined.
module tb_core_alu_wb;
  import core_alu_wb_pkg::*;

  logic        clk_i = 1'b0;
  logic        rst_n_i;
  logic        wb_start_i;
  logic [4:0]  wb_opcode_i;
  logic [15:0] alu_result_i;
  logic        alu_cy_i, alu_ac_i, alu_ov_i;
  logic        psw_wr_i;
  logic [7:0]  psw_data_i;
  logic        sfr_we_o;
  logic [7:0]  sfr_addr_o, sfr_data_o;
  logic        sfr_ack_i;
  logic [7:0]  acc_o, psw_o;
  logic        cy_o, ac_o, ov_o, eq_o, busy_o, done_o;

  int n_tests = 0;
  int n_fail  = 0;

  core_alu_wb dut (
    .clk_i        (clk_i),
    .rst_n_i      (rst_n_i),
    .wb_start_i   (wb_start_i),
    .wb_opcode_i  (wb_opcode_i),
    .alu_result_i (alu_result_i),
    .alu_cy_i     (alu_cy_i),
    .alu_ac_i     (alu_ac_i),
    .alu_ov_i     (alu_ov_i),
    .psw_wr_i     (psw_wr_i),
    .psw_data_i   (psw_data_i),
    .sfr_we_o     (sfr_we_o),
    .sfr_addr_o   (sfr_addr_o),
    .sfr_data_o   (sfr_data_o),
    .sfr_ack_i    (sfr_ack_i),
    .acc_o        (acc_o),
    .psw_o        (psw_o),
    .cy_o         (cy_o),
    .ac_o         (ac_o),
    .ov_o         (ov_o),
    .eq_o         (eq_o),
    .busy_o       (busy_o),
    .done_o       (done_o)
  );

  always #5 clk_i = ~clk_i;

  task automatic check(input string tag, input logic [15:0] act, input logic [15:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", tag, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk_i);
    #1;
  endtask

  // Check write strobe, address and data together.
  task automatic check_sfr(input string tag, input logic we, input logic [7:0] addr,
                           input logic [7:0] data);
    check({tag, "_we"},   {15'd0, sfr_we_o}, {15'd0, we});
    check({tag, "_addr"}, {8'd0, sfr_addr_o}, {8'd0, addr});
    check({tag, "_data"}, {8'd0, sfr_data_o}, {8'd0, data});
  endtask

  task automatic start(input logic [4:0] op, input logic [15:0] res,
                       input logic cy, input logic ac, input logic ov);
    wb_start_i   = 1'b1;
    wb_opcode_i  = op;
    alu_result_i = res;
    alu_cy_i     = cy;
    alu_ac_i     = ac;
    alu_ov_i     = ov;
  endtask

  initial begin
    rst_n_i      = 1'b0;
    wb_start_i   = 1'b0;
    wb_opcode_i  = ALU_ADD;
    alu_result_i = 16'h0000;
    alu_cy_i     = 1'b0;
    alu_ac_i     = 1'b0;
    alu_ov_i     = 1'b0;
    psw_wr_i     = 1'b0;
    psw_data_i   = 8'h00;
    sfr_ack_i    = 1'b0;
    #12;
    check("rst_acc",  {8'd0, acc_o}, 16'h0000);
    check("rst_psw",  {8'd0, psw_o}, 16'h0000);
    check("rst_busy", {15'd0, busy_o}, 16'h0000);
    check("rst_done", {15'd0, done_o}, 16'h0000);
    check_sfr("rst", 1'b0, 8'h00, 8'h00);
    rst_n_i = 1'b1;
    tick();

    // ADD 0x0042, cy=1: one ACC write, done two cycles after start.
    start(ALU_ADD, 16'h0042, 1'b1, 1'b0, 1'b0);
    tick();
    wb_start_i = 1'b0;
    check_sfr("add_wracc", 1'b1, 8'hE0, 8'h42);
    check("add_busy", {15'd0, busy_o}, 16'h0001);
    check("add_cy_capture", {15'd0, cy_o}, 16'h0001);
    check("add_done_early", {15'd0, done_o}, 16'h0000);
    tick();
    check("add_done", {15'd0, done_o}, 16'h0001);
    check("add_acc", {8'd0, acc_o}, 16'h0042);
    check("add_psw", {8'd0, psw_o}, 16'h0080);
    check_sfr("add_donest", 1'b0, 8'h00, 8'h00);
    tick();
    check("add_idle_busy", {15'd0, busy_o}, 16'h0000);
    check("add_idle_done", {15'd0, done_o}, 16'h0000);

    // MUL 0x1234, ov=1; a start request while busy must be ignored.
    start(ALU_MUL, 16'h1234, 1'b0, 1'b0, 1'b1);
    tick();
    start(ALU_ADD, 16'hFFFF, 1'b1, 1'b1, 1'b0);
    check_sfr("mul_wracc", 1'b1, 8'hE0, 8'h34);
    check("mul_ov", {15'd0, ov_o}, 16'h0001);
    tick();
    wb_start_i = 1'b0;
    check_sfr("mul_wrb", 1'b1, 8'hF0, 8'h12);
    check("mul_acc_mid", {8'd0, acc_o}, 16'h0034);
    check("mul_busy_ignore_cy", {15'd0, cy_o}, 16'h0000);
    tick();
    check("mul_done", {15'd0, done_o}, 16'h0001);
    check("mul_psw", {8'd0, psw_o}, 16'h0005);
    tick();
    check("mul_idle", {15'd0, busy_o}, 16'h0000);

    // DIV 0x0703: quotient to ACC, remainder to B.
    start(ALU_DIV, 16'h0703, 1'b0, 1'b0, 1'b0);
    tick();
    wb_start_i = 1'b0;
    check_sfr("div_wracc", 1'b1, 8'hE0, 8'h07);
    tick();
    check_sfr("div_wrb", 1'b1, 8'hF0, 8'h03);
    tick();
    check("div_done", {15'd0, done_o}, 16'h0001);
    check("div_psw", {8'd0, psw_o}, 16'h0001);
    tick();

    // COMP result=1, cy=0: straight to DONE, no SFR write.
    start(ALU_COMP, 16'h0001, 1'b0, 1'b0, 1'b0);
    tick();
    wb_start_i = 1'b0;
    check("comp_done", {15'd0, done_o}, 16'h0001);
    check_sfr("comp", 1'b0, 8'h00, 8'h00);
    check("comp_eq", {15'd0, eq_o}, 16'h0001);
    check("comp_acc", {8'd0, acc_o}, 16'h0007);
    tick();
    check("comp_eq_hold", {15'd0, eq_o}, 16'h0001);
    check("comp_idle_done", {15'd0, done_o}, 16'h0000);

    // Set OV directly, then COMP must change CY only.
    psw_wr_i   = 1'b1;
    psw_data_i = 8'h04;
    tick();
    psw_wr_i = 1'b0;
    check("pswwr_ov", {8'd0, psw_o}, 16'h0005);
    start(ALU_COMP, 16'h0000, 1'b1, 1'b1, 1'b0);
    tick();
    wb_start_i = 1'b0;
    check("comp2_psw", {8'd0, psw_o}, 16'h0085);
    check("comp2_eq", {15'd0, eq_o}, 16'h0000);
    tick();

    // Direct write of all ones: P comes from ACC parity, not from the data.
    psw_wr_i   = 1'b1;
    psw_data_i = 8'hFE;
    tick();
    psw_wr_i = 1'b0;
    check("pswwr_ff", {8'd0, psw_o}, 16'h00FF);
    check("pswwr_flags", {13'd0, cy_o, ac_o, ov_o}, 16'h0007);

    // Direct PSW write on the capture edge overrides captured flags.
    start(ALU_ADD, 16'h0055, 1'b0, 1'b1, 1'b1);
    psw_wr_i   = 1'b1;
    psw_data_i = 8'h80;
    tick();
    wb_start_i = 1'b0;
    psw_wr_i   = 1'b0;
    check("coll_flags", {13'd0, cy_o, ac_o, ov_o}, 16'h0004);
    check("coll_psw", {8'd0, psw_o}, 16'h0081);
`ifdef ALU_WB_SFR_ACK_EN
    for (int i = 0; i < 4; i++) begin
      if (i == 3) sfr_ack_i = 1'b1;
      check_sfr("ack_hold", 1'b1, 8'hE0, 8'h55);
      tick();
    end
    sfr_ack_i = 1'b0;
`else
    check_sfr("coll_wracc", 1'b1, 8'hE0, 8'h55);
    tick();
`endif
    check("coll_done", {15'd0, done_o}, 16'h0001);
    check("coll_psw_end", {8'd0, psw_o}, 16'h0080);
    tick();

    // Reset during WR_B of a MUL aborts the commit.
    start(ALU_MUL, 16'hABCD, 1'b1, 1'b1, 1'b1);
    tick();
    wb_start_i = 1'b0;
`ifdef ALU_WB_SFR_ACK_EN
    sfr_ack_i = 1'b1;
`endif
    tick();
    check_sfr("mid_wrb", 1'b1, 8'hF0, 8'hAB);
    rst_n_i = 1'b0;
    #1;
    check_sfr("mid_rst", 1'b0, 8'h00, 8'h00);
    check("mid_rst_acc", {8'd0, acc_o}, 16'h0000);
    check("mid_rst_psw", {8'd0, psw_o}, 16'h0000);
    check("mid_rst_state", {13'd0, busy_o, done_o, eq_o}, 16'h0000);
    #3;
    rst_n_i = 1'b1;
    for (int i = 0; i < 4; i++) begin
      tick();
      check("post_rst_we", {14'd0, sfr_we_o, busy_o}, 16'h0000);
    end
    sfr_ack_i = 1'b0;

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule

// File: doc/core_alu_wb.md
CORE_ALU_WB -- requirements
Module: core_alu_wb

Interface
REQ-001 SHALL have ports: clk_i  in  1  core clock, rising edge.
REQ-002 SHALL have ports: rst_n_i  in  1  reset, asynchronous, active-low.
REQ-003 SHALL have ports: wb_start_i  in  1  one-cycle request to commit the current ALU output.
REQ-004 SHALL have ports: wb_opcode_i  in  5  ALU opcode of the committed operation.
REQ-005 SHALL have ports: alu_result_i  in  16  ALU result.
REQ-006 SHALL have ports: alu_cy_i, alu_ac_i, alu_ov_i  in  1 each  ALU flag outputs.
REQ-007 SHALL have ports: psw_wr_i  in  1  direct PSW write strobe; psw_data_i  in  8  PSW write data.
REQ-008 SHALL have ports: sfr_we_o  out  1  SFR write strobe; sfr_addr_o  out  8  SFR address; sfr_data_o  out  8  SFR data.
REQ-009 SHALL have ports: sfr_ack_i  in  1  SFR write accepted.
REQ-010 SHALL have ports: acc_o  out  8  shadow ACC; psw_o  out  8  {CY,AC,F0,RS1,RS0,OV,F1,P}.
REQ-011 SHALL have ports: cy_o, ac_o, ov_o  out  1 each  flags fed back to the ALU.
REQ-012 SHALL have ports: eq_o  out  1  COMP equal result; busy_o  out  1  commit in progress; done_o  out  1  one-cycle completion pulse.

Function
REQ-013 SHALL implement FSM IDLE -> WR_ACC -> WR_B -> DONE -> IDLE; WR_B is entered only for ALU_MUL/ALU_DIV.
REQ-014 In IDLE, wb_start_i SHALL capture alu_result_i, the flags and wb_opcode_i into internal registers in the same edge; busy_o=1 from the next cycle until DONE exits.
REQ-015 wb_start_i while busy_o=1 SHALL be ignored.
REQ-016 CY/AC/OV in psw_o SHALL update on the capture edge; P SHALL always equal XOR of acc_o.
REQ-017 WR_ACC SHALL drive sfr_we_o=1, sfr_addr_o=8'hE0, sfr_data_o=ACC value; acc_o SHALL update when the write completes.
REQ-018 ACC value: MUL -> result[7:0]; DIV -> result[15:8]; all others -> result[7:0].
REQ-019 WR_B SHALL write sfr_addr_o=8'hF0 with MUL -> result[15:8], DIV -> result[7:0].
REQ-020 ALU_COMP SHALL skip WR_ACC and WR_B (IDLE -> DONE), update CY only, and register eq_o=result[0]; eq_o SHALL hold until the next capture.
REQ-021 done_o SHALL pulse for exactly one cycle in DONE; sfr_we_o=0 in IDLE and DONE; sfr_addr_o/sfr_data_o=0 when sfr_we_o=0.
REQ-022 psw_wr_i SHALL load psw_o[7:1] from psw_data_i in any state; P is recomputed, never written.
REQ-023 If psw_wr_i and a capture occur on the same edge, psw_wr_i SHALL win for all written bits.
REQ-024 cy_o/ac_o/ov_o SHALL equal psw_o[7]/[6]/[2] combinationally.
REQ-025 Latency without wait states: ADD -> done_o 2 cycles after wb_start_i; MUL/DIV -> 3 cycles; COMP -> 1 cycle.

Reset
REQ-026 rst_n_i low SHALL asynchronously force state IDLE, acc_o=0, psw_o=0, eq_o=0, busy_o=0, done_o=0, sfr_we_o=0.
REQ-027 Reset mid-operation SHALL abort the commit with no further SFR write.

Configuration
REQ-028 With ALU_WB_SFR_ACK_EN defined, WR_ACC/WR_B SHALL hold sfr_we_o, sfr_addr_o and sfr_data_o stable until sfr_ack_i=1, then advance.
REQ-029 Without ALU_WB_SFR_ACK_EN, each write state SHALL last exactly one cycle and sfr_ack_i SHALL be ignored.

Structure
REQ-030 ALU opcode constants (ALU_ADD ... ALU_DIV), SFR addresses (ACC, B, PSW), PSW bit indices and FSM state encodings SHALL reside in the shared instruction-set package.
REQ-031 The block SHALL be a single module with no sub-modules; the parity function is inline.

Verification
REQ-032 ADD: result=16'h0042, cy=1 -> sfr write E0/42, acc_o=42, psw_o[7]=1, P=0, done_o after 2 cycles.
REQ-033 MUL: result=16'h1234, ov=1 -> writes E0/34 then F0/12, ov_o=1, done_o after 3 cycles.
REQ-034 DIV: result=16'h0703 -> writes E0/07 then F0/03.
REQ-035 COMP: result=1, cy=0 -> no sfr_we_o, eq_o=1, done_o after 1 cycle.
REQ-036 With ALU_WB_SFR_ACK_EN, sfr_ack_i delayed 3 cycles -> E0 write held 4 cycles; a concurrent psw_wr_i=8'h80 on the capture edge gives cy_o=1.
REQ-037 rst_n_i asserted during WR_B of MUL -> outputs at reset values immediately; no F0 write after release.
